// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - registered multi-mode immediate extender with result FIFO
//
// Extends the raw instruction immediate field according to in_mode and queues
// the result in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready depends on FIFO state only
//   in_imm[29:0]          raw field instr[29:0], LSB-aligned
//   in_mode[1:0]          0=SIMM13 1=DISP22 2=DISP30 3=IMM22
//   in_zext               (IMMX_ZEXT_EN only) zero-fill instead of sign-fill
//   out_valid/out_ready   output handshake
//   out_data[OUT_W-1:0]   extended operand at FIFO head (0 when empty)
//   out_mode[1:0]         mode tag at FIFO head (0 when empty)
//   occupancy             number of entries held
//
// Configuration macro: IMMX_ZEXT_EN

module imm_extend_unit #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [29:0]                in_imm,
    input  logic [1:0]                 in_mode,
`ifdef IMMX_ZEXT_EN
    input  logic                       in_zext,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [1:0]                 out_mode,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             zext;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] ext;

`ifdef IMMX_ZEXT_EN
    assign zext = in_zext;
`else
    assign zext = 1'b0;
`endif

    // The extension is resolved at push time, so each entry already carries
    // its own fill choice and the output side is a plain register read.
    always_comb begin
        ext = '0;
        case (in_mode)
            2'd0:    ext = {{(OUT_W-13){in_imm[12] & ~zext}}, in_imm[12:0]};
            2'd1:    ext = {{(OUT_W-22){in_imm[21] & ~zext}}, in_imm[21:0]} << 2;
            2'd2:    ext = {{(OUT_W-30){in_imm[29] & ~zext}}, in_imm[29:0]} << 2;
            default: ext = {{(OUT_W-22){1'b0}}, in_imm[21:0]} << 10;
        endcase
    end

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_mode  = out_valid ? mem_mode[rd_ptr] : 2'd0;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ext;
            mem_mode[wr_ptr] <= in_mode;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - randomized self-checking bench for imm_extend_unit

module tb_imm_extend_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic [1:0]  occupancy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q_data [$];
    logic [1:0]  q_mode [$];

    always #5 clk = ~clk;

    imm_extend_unit #(.OUT_W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference extension: interpret each field as a two's-complement (or
    // unsigned) integer and scale it, instead of assembling bit fields.
    function automatic logic [31:0] ref_ext(input logic [29:0] imm, input logic [1:0] mode);
        longint v;
        case (mode)
            2'd0: begin
                v = longint'(imm) % 8192;
                if (v >= 4096) v = v - 8192;
            end
            2'd1: begin
                v = longint'(imm) % 4194304;
                if (v >= 2097152) v = v - 4194304;
                v = v * 4;
            end
            2'd2: begin
                v = longint'(imm);
                if (v >= 536870912) v = v - 1073741824;
                v = v * 4;
            end
            default: v = (longint'(imm) % 4194304) * 1024;
        endcase
        return v[31:0];
    endfunction

    task automatic check_outputs();
        logic [31:0] ed;
        logic [1:0]  em;
        ed = (q_data.size() > 0) ? q_data[0] : 32'd0;
        em = (q_mode.size() > 0) ? q_mode[0] : 2'd0;
        check("in_ready", {63'd0, in_ready}, {63'd0, q_data.size() < DEPTH});
        check("out_valid", {63'd0, out_valid}, {63'd0, q_data.size() > 0});
        check("occupancy", {62'd0, occupancy}, 64'(q_data.size()));
        check("out_data", {32'd0, out_data}, {32'd0, ed});
        check("out_mode", {62'd0, out_mode}, {62'd0, em});
    endtask

    // Called on a falling edge: check state, drive one cycle, return on the next falling edge.
    task automatic cycle(input logic v, input logic [29:0] imm, input logic [1:0] mode,
                         input logic ordy, output logic accepted);
        logic mv;
        check_outputs();
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = ordy;
        mv        = q_data.size() > 0;
        accepted  = v && (q_data.size() < DEPTH);
        @(posedge clk);
        if (mv && ordy) begin
            void'(q_data.pop_front());
            void'(q_mode.pop_front());
        end
        if (accepted) begin
            q_data.push_back(ref_ext(imm, mode));
            q_mode.push_back(mode);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        q_data.delete();
        q_mode.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [29:0] d_imm [5] = '{30'h1FFF, 30'h200000, 30'h1, 30'h3FFFFF, 30'h0FFF};
    logic [1:0]  d_mode[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] d_exp [5] = '{32'hFFFF_FFFF, 32'hFF80_0000, 32'h0000_0004,
                               32'hFFFF_FC00, 32'h0000_0FFF};

    initial begin
        logic        acc;
        logic [29:0] p_imm;
        logic [1:0]  p_mode;
        logic        p_valid;

        @(negedge clk);
        do_reset();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);

        // Directed extension cases: each beat shows up one cycle after acceptance.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, d_imm[i], d_mode[i], 1'b1, acc);
            check("dir_valid", {63'd0, out_valid}, 64'd1);
            check("dir_data", {32'd0, out_data}, {32'd0, d_exp[i]});
        end
        cycle(1'b0, '0, '0, 1'b1, acc);

        // Fill with consumer stalled; third beat must hold until a slot frees.
        cycle(1'b1, 30'h0000123, 2'd0, 1'b0, acc);
        cycle(1'b1, 30'h0200000, 2'd1, 1'b0, acc);
        cycle(1'b1, 30'h3FFFFFF, 2'd2, 1'b0, acc);
        check("full_third_held", {63'd0, acc}, 64'd0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 30'h3FFFFFF, 2'd2, 1'b0, acc);
        check("full_stall_data", {32'd0, out_data}, {32'd0, 32'h0000_0123});
        cycle(1'b1, 30'h3FFFFFF, 2'd2, 1'b1, acc);
        check("full_pop_no_push", {63'd0, acc}, 64'd0);
        cycle(1'b1, 30'h3FFFFFF, 2'd2, 1'b1, acc);
        check("third_enters", {63'd0, acc}, 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, acc);

        // Streaming at occupancy 1.
        cycle(1'b1, 30'h15, 2'd3, 1'b0, acc);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 30'(i * 37 + 1), 2'(i), 1'b1, acc);
            check("stream_occ", {62'd0, occupancy}, 64'd1);
        end

        // Reset with two entries queued.
        cycle(1'b1, 30'h7, 2'd0, 1'b0, acc);
        check("pre_reset_occ", {62'd0, occupancy}, 64'd2);
        do_reset();
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_data", {32'd0, out_data}, 64'd0);
        check("mid_rst_occ", {62'd0, occupancy}, 64'd0);

        // Randomized traffic; a stalled beat is held stable until accepted.
        p_valid = 1'b0;
        p_imm   = '0;
        p_mode  = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!p_valid || acc) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_imm   = 30'($urandom);
                p_mode  = 2'($urandom_range(0, 3));
            end
            cycle(p_valid, p_imm, p_mode, 1'($urandom_range(0, 2) != 0), acc);
            if (!p_valid) acc = 1'b1;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
